// File: rtl/word_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_buf_pkg
// Description : Shared types and constants for the word skid buffer.
// Revision    : 1.0
// ============================================================================
package word_buf_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   function automatic logic [1:0] state_count(input skid_state_t s);
      logic [1:0] n;
      n = 2'd0;
      case (s)
         EMPTY:   n = 2'd0;
         BUSY:    n = 2'd1;
         FULL:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/skid_data_reg.sv
`default_nettype none
// ============================================================================
// Module      : skid_data_reg
// Description : Enable-loaded data register, async active-low reset to zero.
// Revision    : 1.0
// ============================================================================
module skid_data_reg
   import word_buf_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] d,
   output logic [DATA_WIDTH-1:0] q
);

   logic [DATA_WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_q <= '0;
      end else if (load) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/word_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : word_skid_buffer
// Description : Two-entry elastic buffer on valid/ready with registered outputs.
// Revision    : 1.0
// ============================================================================
module word_skid_buffer
   import word_buf_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            count
);

   skid_state_t           r_state;
   skid_state_t           w_next_state;
   logic                  r_started;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic [1:0]            r_count;
   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_main_load;
   logic                  w_skid_load;
   logic [DATA_WIDTH-1:0] w_main_d;
   logic [DATA_WIDTH-1:0] w_main_q;
   logic [DATA_WIDTH-1:0] w_skid_q;

   assign w_in_fire  = in_valid & r_in_ready;
   assign w_out_fire = r_out_valid & out_ready;

   always_comb begin
      w_next_state = r_state;
      w_main_load  = 1'b0;
      w_skid_load  = 1'b0;
      w_main_d     = in_data;
      case (r_state)
         EMPTY: begin
            if (w_in_fire) begin
               w_main_load  = 1'b1;
               w_next_state = BUSY;
            end
         end
         BUSY: begin
            if (w_in_fire && w_out_fire) begin
               w_main_load = 1'b1;
            end else if (w_in_fire) begin
               w_skid_load  = 1'b1;
               w_next_state = FULL;
            end else if (w_out_fire) begin
               w_next_state = EMPTY;
            end
         end
         FULL: begin
            if (w_out_fire) begin
               w_main_load  = 1'b1;
               w_main_d     = w_skid_q;
               w_next_state = BUSY;
            end
         end
         default: w_next_state = EMPTY;
      endcase
      // Flush wins over any fire and leaves the data registers untouched.
      if (clear) begin
         w_next_state = EMPTY;
         w_main_load  = 1'b0;
         w_skid_load  = 1'b0;
      end
   end

   // Handshake outputs are registered from the next state so no comb path exists.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state     <= EMPTY;
         r_started   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_state     <= w_next_state;
         r_started   <= 1'b1;
         r_in_ready  <= (w_next_state != FULL);
         r_out_valid <= (w_next_state != EMPTY);
         r_count     <= state_count(w_next_state);
      end
   end

   skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_main_reg (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (w_main_load),
      .d     (w_main_d),
      .q     (w_main_q)
   );

   skid_data_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid_reg (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (w_skid_load),
      .d     (in_data),
      .q     (w_skid_q)
   );

   assign in_ready  = r_in_ready & r_started;
   assign out_valid = r_out_valid;
   assign out_data  = w_main_q;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_word_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_skid_buffer
// Description : Directed and randomized checks of word_skid_buffer.
// Revision    : 1.0
// ============================================================================
module tb_word_skid_buffer;

   logic        clk;
   logic        n_rst;
   logic        clear;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  count;

   int n_cmp;
   int n_err;

   word_skid_buffer #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .clear     (clear),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   logic [31:0] q[$];
   bit          m_in_fire;
   bit          m_out_fire;

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      n_rst     = 1'b0;
      clear     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_count",     {30'd0, count},     32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);

      // 1: release with a word already waiting
      @(negedge clk);
      n_rst    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hA5A5_0001;
      #1;
      chk("t1_ready_release", {31'd0, in_ready}, 32'd0);
      tick();
      chk("t1_ready_up",      {31'd0, in_ready},  32'd1);
      chk("t1_not_yet_valid", {31'd0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_data",  out_data,           32'hA5A5_0001);
      chk("t1_count", {30'd0, count},     32'd1);
      out_ready = 1'b1;
      tick();
      chk("t1_drained", {30'd0, count}, 32'd0);

      // 2: streaming at full rate
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = i;
         tick();
         chk("t2_data",  out_data,           i);
         chk("t2_valid", {31'd0, out_valid}, 32'd1);
         chk("t2_count", {30'd0, count},     32'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("t2_empty_valid", {31'd0, out_valid}, 32'd0);
      chk("t2_empty_count", {30'd0, count},     32'd0);

      // 3: back-pressure fills the skid slot
      out_ready = 1'b0;
      push(32'h10);
      chk("t3_busy_count", {30'd0, count}, 32'd1);
      push(32'h11);
      chk("t3_full_count", {30'd0, count},    32'd2);
      chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
      chk("t3_full_data",  out_data,          32'h10);
      tick();
      chk("t3_stall_data",  out_data,       32'h10);
      chk("t3_stall_count", {30'd0, count}, 32'd2);
      out_ready = 1'b1;
      tick();
      chk("t3_pop1_data",  out_data,          32'h11);
      chk("t3_pop1_ready", {31'd0, in_ready}, 32'd1);
      chk("t3_pop1_count", {30'd0, count},    32'd1);
      tick();
      chk("t3_pop2_count", {30'd0, count}, 32'd0);

      // 4: clear while full, together with a pop
      out_ready = 1'b0;
      push(32'h20);
      push(32'h21);
      chk("t4_full_count", {30'd0, count}, 32'd2);
      clear     = 1'b1;
      out_ready = 1'b1;
      tick();
      clear = 1'b0;
      chk("t4_clr_count", {30'd0, count},     32'd0);
      chk("t4_clr_valid", {31'd0, out_valid}, 32'd0);
      chk("t4_clr_ready", {31'd0, in_ready},  32'd1);
      tick();
      chk("t4_no_ghost", {31'd0, out_valid}, 32'd0);
      // an incoming word in the clear cycle is discarded
      in_valid = 1'b1;
      in_data  = 32'h22;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t4_clr_in_drop", {31'd0, out_valid}, 32'd0);
      push(32'h23);
      chk("t4_after_data", out_data, 32'h23);
      tick();
      chk("t4_after_empty", {30'd0, count}, 32'd0);

      // 5: asynchronous reset mid-cycle
      out_ready = 1'b0;
      push(32'h30);
      chk("t5_busy_valid", {31'd0, out_valid}, 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("t5_async_valid", {31'd0, out_valid}, 32'd0);
      chk("t5_async_count", {30'd0, count},     32'd0);
      chk("t5_async_ready", {31'd0, in_ready},  32'd0);
      @(negedge clk);
      n_rst    = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h31;
      tick();
      chk("t5_rel_valid", {31'd0, out_valid}, 32'd0);
      tick();
      in_valid = 1'b0;
      chk("t5_first_data",  out_data,       32'h31);
      chk("t5_first_count", {30'd0, count}, 32'd1);
      out_ready = 1'b1;
      tick();
      chk("t5_drain", {30'd0, count}, 32'd0);

      // 6: random traffic against a reference queue
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         out_ready = $urandom_range(0, 1) == 1;
         m_in_fire  = in_valid && (q.size() < 2);
         m_out_fire = out_ready && (q.size() > 0);
         tick();
         if (m_out_fire) void'(q.pop_front());
         if (m_in_fire)  q.push_back(in_data);
         chk("t6_count", {30'd0, count},     q.size());
         chk("t6_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
         chk("t6_ready", {31'd0, in_ready},  (q.size() < 2) ? 32'd1 : 32'd0);
         if (q.size() > 0) chk("t6_data", out_data, q[0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/word_skid_buffer.md
Name: word_skid_buffer

Overview:
- Two-entry elastic buffer for 32-bit words on a valid/ready handshake.
- It is the consuming counterpart of the unconditional one-clock delay register. It accepts words from an upstream producer, absorbs one cycle of downstream back-pressure without losing data, and re-presents words in order.
- Sits between pipeline stages where the downstream consumer can stall.
- All handshake outputs are driven from registers, with no combinational ready/valid path through the block.

Parameters:
- DATA_WIDTH, 32, width of each buffered word.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset: asynchronous, active-low; clock clk.
- clear  input  1  synchronous flush; discards all held words.
- in_data  input  DATA_WIDTH  upstream word.
- in_valid  input  1  upstream word present.
- in_ready  output  1  buffer can accept a word this cycle.
- out_data  output  DATA_WIDTH  word presented downstream.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts out_data this cycle.
- count  output  2  number of words held (0..2).

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - main_reg drives out_data.
  - skid_reg holds the overflow word.
- State machine: EMPTY (count 0), BUSY (count 1), FULL (count 2).
- Reset (n_rst low, async):
  - state = EMPTY; main_reg = 0; skid_reg = 0.
  - out_valid = 0; count = 0; in_ready = 0.
  - in_ready stays 0 until the first rising clk after n_rst deasserts, via a started flop (reset 0, set 1 on the first clock). Afterwards in_ready = started & (state != FULL).
- Output decode:
  - out_valid = (state != EMPTY).
  - count = 0/1/2 for EMPTY/BUSY/FULL.
  - out_data = main_reg, whose value is don't-care while EMPTY.
- Transitions, evaluated per rising edge when clear = 0:
  - EMPTY, in_fire: main_reg <= in_data; go to BUSY.
  - EMPTY, no in_fire: hold.
  - BUSY, in_fire & out_fire: main_reg <= in_data; stay BUSY.
  - BUSY, in_fire only: skid_reg <= in_data; go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL (in_ready = 0, so in_fire is impossible), out_fire: main_reg <= skid_reg; go to BUSY.
  - FULL, no out_fire: hold; out_data stays stable.
- Latency and throughput:
  - Accepted word appears on out_data with out_valid = 1 on the next cycle (1-cycle latency).
  - Sustained throughput is 1 word/cycle while out_ready = 1.
- Ordering: strict FIFO; no word is duplicated or dropped.
- clear:
  - Takes priority over any fire in the same cycle; next state is EMPTY.
  - Data registers are left unchanged.
  - An in_fire in the clear cycle is discarded; an out_fire in the clear cycle is counted as consumed by the downstream.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid hold unchanged.
- Upstream protocol:
  - in_valid may drop without in_fire; the buffer takes no action.
  - in_data is sampled only on in_fire.
- Reset mid-operation: all held words are lost and the outputs take their reset values immediately (async).

Decomposition:
- Package word_buf_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2}.
  - localparam DATA_WIDTH_DEFAULT = 32.
- Sub-module: skid_data_reg, an enable-loaded DATA_WIDTH register with async active-low reset to 0. It is instantiated twice (main_reg, skid_reg).
- The state machine and handshake decode stay in word_skid_buffer.

Test Plan:
1. Reset, then release n_rst with in_valid = 1, in_data = 32'hA5A5_0001 -> in_ready = 0 in the release cycle; in_ready = 1 on the next edge; word accepted; following cycle out_valid = 1, out_data = 32'hA5A5_0001, count = 1.
2. Stream 32'h1..32'h8 with out_ready held 1 -> one word out per cycle, in order, count never exceeds 1, 1-cycle latency.
3. BUSY holding 32'h10, out_ready = 0, push 32'h11 -> count = 2, in_ready = 0, out_data = 32'h10 stable; raise out_ready -> 32'h10 then 32'h11 emitted; in_ready returns 1 after the first pop.
4. FULL (32'h20, 32'h21), assert clear together with out_ready = 1 -> next cycle count = 0, out_valid = 0, in_ready = 1; 32'h21 is never emitted.
5. BUSY, assert n_rst = 0 asynchronously mid-cycle -> out_valid, count and in_ready go to 0 before the next edge; after release the first output is the next pushed word only.
6. Random in_valid/out_ready over 10k cycles against a reference queue model -> identical output sequence, out_data stable under stall, count matches queue occupancy every cycle.
